// File: rtl/pipe_divider.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_divider
//  Description : 8-stage pipelined unsigned restoring divider.
//                16-bit dividend / 8-bit divisor -> 8-bit quotient and
//                8-bit remainder, one quotient bit per stage, MSB first.
//                One operation accepted per clock, results in issue order.
//                Optional macro PIPE_DIV_ZERO_FLAG_EN adds a div_zero output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_divider #(
    parameter int STAGES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] din1,
    input  logic [7:0]  din2,
    output logic        out_valid,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
`ifdef PIPE_DIV_ZERO_FLAG_EN
    output logic        div_zero,
`endif
    output logic        overflow
);

    localparam int c_QW = 8;

    // The quotient is resolved one bit per stage, so the depth is locked to
    // the quotient width.
    if (STAGES != c_QW) begin : g_bad_stages
        $error("pipe_divider: STAGES must be 8");
    end

    // Per-stage operand bundle entering step i (index 0 = input register).
    // The partial remainder is held as 8 bits: its 9th bit is always 0 for a
    // non-overflowing operation, so any carry out is folded into the ovf flag.
    logic       w_vld [0:STAGES-1];
    logic [7:0] w_rem [0:STAGES-1];
    logic [7:0] w_low [0:STAGES-1];
    logic [7:0] w_div [0:STAGES-1];
    logic [7:0] w_q   [0:STAGES-1];
    logic       w_ovf [0:STAGES-1];
`ifdef PIPE_DIV_ZERO_FLAG_EN
    logic       w_dz  [0:STAGES-1];
    logic       r_in_dz;
    logic       r_dz_out;
`endif

    logic       r_in_vld;
    logic [7:0] r_in_rem;
    logic [7:0] r_in_low;
    logic [7:0] r_in_div;
    logic       r_in_ovf;

    logic       r_out_vld;
    logic [7:0] r_quot;
    logic [7:0] r_rem_out;
    logic       r_ovf_out;

    // Input stage: capture operands and flag overflow (also catches din2 == 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_vld <= 1'b0;
            r_in_rem <= '0;
            r_in_low <= '0;
            r_in_div <= '0;
            r_in_ovf <= 1'b0;
`ifdef PIPE_DIV_ZERO_FLAG_EN
            r_in_dz  <= 1'b0;
`endif
        end else begin
            r_in_vld <= in_valid;
            if (in_valid) begin
                r_in_rem <= din1[15:8];
                r_in_low <= din1[7:0];
                r_in_div <= din2;
                r_in_ovf <= (din1[15:8] >= din2);
`ifdef PIPE_DIV_ZERO_FLAG_EN
                r_in_dz  <= (din2 == 8'd0);
`endif
            end
        end
    end

    assign w_vld[0] = r_in_vld;
    assign w_rem[0] = r_in_rem;
    assign w_low[0] = r_in_low;
    assign w_div[0] = r_in_div;
    assign w_q[0]   = '0;
    assign w_ovf[0] = r_in_ovf;
`ifdef PIPE_DIV_ZERO_FLAG_EN
    assign w_dz[0]  = r_in_dz;
`endif

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [8:0] w_shift;
        logic       w_ge;
        logic [8:0] w_rem_nxt;
        logic [7:0] w_q_nxt;
        logic       w_ovf_nxt;

        // Restoring step: bring down the next dividend bit, subtract if it fits.
        assign w_shift   = {w_rem[i], w_low[i][STAGES-1-i]};
        assign w_ge      = (w_shift >= {1'b0, w_div[i]});
        assign w_rem_nxt = w_ge ? (w_shift - {1'b0, w_div[i]}) : w_shift;
        assign w_ovf_nxt = w_ovf[i] | w_rem_nxt[8];

        // Set this stage's quotient bit in place; other bits pass through.
        always_comb begin
            w_q_nxt                = w_q[i];
            w_q_nxt[STAGES-1-i]    = w_ge;
        end

        if (i < STAGES - 1) begin : g_mid
            logic       r_vld;
            logic [7:0] r_rem;
            logic [7:0] r_low;
            logic [7:0] r_div;
            logic [7:0] r_q;
            logic       r_ovf;
`ifdef PIPE_DIV_ZERO_FLAG_EN
            logic       r_dz;
`endif

            // Stage register: data loads only behind a valid operation.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_rem <= '0;
                    r_low <= '0;
                    r_div <= '0;
                    r_q   <= '0;
                    r_ovf <= 1'b0;
`ifdef PIPE_DIV_ZERO_FLAG_EN
                    r_dz  <= 1'b0;
`endif
                end else begin
                    r_vld <= w_vld[i];
                    if (w_vld[i]) begin
                        r_rem <= w_rem_nxt[7:0];
                        r_low <= w_low[i];
                        r_div <= w_div[i];
                        r_q   <= w_q_nxt;
                        r_ovf <= w_ovf_nxt;
`ifdef PIPE_DIV_ZERO_FLAG_EN
                        r_dz  <= w_dz[i];
`endif
                    end
                end
            end

            assign w_vld[i+1] = r_vld;
            assign w_rem[i+1] = r_rem;
            assign w_low[i+1] = r_low;
            assign w_div[i+1] = r_div;
            assign w_q[i+1]   = r_q;
            assign w_ovf[i+1] = r_ovf;
`ifdef PIPE_DIV_ZERO_FLAG_EN
            assign w_dz[i+1]  = r_dz;
`endif
        end else begin : g_last
            // Output register: overflowed operations report all-ones results;
            // outputs hold the last result across bubbles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_vld <= 1'b0;
                    r_quot    <= '0;
                    r_rem_out <= '0;
                    r_ovf_out <= 1'b0;
`ifdef PIPE_DIV_ZERO_FLAG_EN
                    r_dz_out  <= 1'b0;
`endif
                end else begin
                    r_out_vld <= w_vld[i];
                    if (w_vld[i]) begin
                        r_quot    <= w_ovf_nxt ? 8'hFF : w_q_nxt;
                        r_rem_out <= w_ovf_nxt ? 8'hFF : w_rem_nxt[7:0];
                        r_ovf_out <= w_ovf_nxt;
`ifdef PIPE_DIV_ZERO_FLAG_EN
                        r_dz_out  <= w_dz[i];
`endif
                    end
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign quotient  = r_quot;
    assign remainder = r_rem_out;
    assign overflow  = r_ovf_out;
`ifdef PIPE_DIV_ZERO_FLAG_EN
    assign div_zero  = r_dz_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_divider
//  Description : Directed self-checking bench for pipe_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] din1 = '0;
    logic [7:0]  din2 = '0;
    logic        out_valid;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        overflow;
`ifdef PIPE_DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  last_q   = '0;
    logic [7:0]  last_r   = '0;

    always #5 clk = ~clk;

    pipe_divider #(.STAGES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din1      (din1),
        .din2      (din2),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder),
`ifdef PIPE_DIV_ZERO_FLAG_EN
        .div_zero  (div_zero),
`endif
        .overflow  (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation alone and check it emerges exactly 8 edges later.
    task automatic op(input logic [15:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic eo, input logic ez, input string tag);
        in_valid = 1'b1;
        din1     = a;
        din2     = b;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk({tag, ".valid"}, out_valid, (c == 8));
        end
        chk({tag, ".q"},   quotient,  eq);
        chk({tag, ".r"},   remainder, er);
        chk({tag, ".ovf"}, overflow,  eo);
`ifdef PIPE_DIV_ZERO_FLAG_EN
        chk({tag, ".dz"},  div_zero,  ez);
`else
        if (ez) begin end
`endif
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic [15:0] qa [$];
        logic [7:0]  qb [$];
        bit          vh [0:30];
        int          ib;
        int          ia;
        logic [15:0] ea;
        logic [7:0]  eb;
        logic [15:0] ident;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid", out_valid, 1'b0);
        chk("reset.q",     quotient,  8'd0);
        chk("reset.r",     remainder, 8'd0);
        chk("reset.ovf",   overflow,  1'b0);
`ifdef PIPE_DIV_ZERO_FLAG_EN
        chk("reset.dz",    div_zero,  1'b0);
`endif
        #3 rst_n = 1'b1;
        tick();
        chk("idle.valid", out_valid, 1'b0);

        // Directed operations
        op(16'd1000, 8'd7,  8'd142, 8'd6,  1'b0, 1'b0, "basic");
        tick();
        chk("basic.after_valid", out_valid, 1'b0);
        chk("basic.hold_q",      quotient,  8'd142);
        op(16'hFEFF, 8'hFF, 8'hFF,  8'hFE, 1'b0, 1'b0, "maxval");
        op(16'h0A00, 8'h0A, 8'hFF,  8'hFF, 1'b1, 1'b0, "ovf_eq");
        op(16'h0005, 8'h00, 8'hFF,  8'hFF, 1'b1, 1'b1, "div0");
        op(16'h09FF, 8'h0A, 8'hFF,  8'h09, 1'b0, 1'b0, "edge_hi");
        op(16'h0000, 8'h01, 8'h00,  8'h00, 1'b0, 1'b0, "zero");

        // Streaming: 20 random non-overflow ops with bubbles at slots 5, 11, 17
        for (int t = 0; t < 31; t++) begin
            if (t < 23 && t != 5 && t != 11 && t != 17) begin
                ib       = int'($urandom_range(1, 255));
                ia       = int'($urandom_range(0, ib * 256 - 1));
                in_valid = 1'b1;
                din1     = 16'(ia);
                din2     = 8'(ib);
                qa.push_back(16'(ia));
                qb.push_back(8'(ib));
                vh[t]    = 1'b1;
            end else begin
                in_valid = 1'b0;
                vh[t]    = 1'b0;
            end
            tick();
            if (t >= 8 && vh[t-8]) begin
                ea    = qa.pop_front();
                eb    = qb.pop_front();
                chk("stream.valid", out_valid, 1'b1);
                chk("stream.q",     quotient,  ea / 16'(eb));
                chk("stream.r",     remainder, ea % 16'(eb));
                chk("stream.ovf",   overflow,  1'b0);
                ident = 16'(quotient) * 16'(eb) + 16'(remainder);
                chk("stream.identity", ident, ea);
                chk("stream.r_lt_d",   (remainder < eb), 1'b1);
                last_q = 8'(ea / 16'(eb));
                last_r = 8'(ea % 16'(eb));
            end else begin
                chk("stream.bubble_valid", out_valid, 1'b0);
                chk("stream.bubble_q",     quotient,  last_q);
                chk("stream.bubble_r",     remainder, last_r);
            end
        end

        // Reset mid-flight: 5 ops in flight, first one just emerged
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            din1     = 16'(100 + k);
            din2     = 8'd3;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("midrst.pre_valid", out_valid, 1'b1);
        chk("midrst.pre_q",     quotient,  8'd33);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.valid", out_valid, 1'b0);
        chk("midrst.q",     quotient,  8'd0);
        chk("midrst.r",     remainder, 8'd0);
        chk("midrst.ovf",   overflow,  1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst.hold_valid", out_valid, 1'b0);
        chk("midrst.hold_r",     remainder, 8'd0);
        #3 rst_n = 1'b1;
        op(16'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b0, "post_reset");
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_reset.idle_valid", out_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
